// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution output stage (conv_stream_out).
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   localparam int unsigned DEF_DATA_W = 32;

   function automatic int unsigned level_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// Synchronous FIFO with a first-word-fall-through output register and an
// occupancy counter; the head word is always presented registered.
module conv_out_fifo
   import conv_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned WORD_W = DEF_DATA_W + 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       wr_en,
   input  logic [WORD_W-1:0]          wr_data,
   input  logic                       rd_en,
   output logic [WORD_W-1:0]          rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [level_w(DEPTH)-1:0]  level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = level_w(DEPTH);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [LW-1:0]     level_after_pop;
   logic [WORD_W-1:0] out_q, out_d;

   always_comb begin
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      level_d         = level_q;
      out_d           = out_q;
      level_after_pop = level_q - LW'(rd_en);
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
         level_d = level_after_pop + LW'(wr_en);
         // Head register tracks the next word; bypass the write when nothing else is queued.
         if (wr_en && (level_after_pop == '0)) begin
            out_d = wr_data;
         end else if (level_after_pop != '0) begin
            out_d = mem_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         out_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         out_q    <= out_d;
      end
   end

   assign rd_data = out_q;
   assign level   = level_q;
   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);

endmodule

// File: rtl/conv_stream_out.sv
// Convolution output stage: buffers core pixels and streams them as AXI4-Stream.
// Optional pixel-count checking is enabled by defining CONV_OUT_CNT_EN.
module conv_stream_out
   import conv_pkg::*;
#(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned FRAME_PIXELS = 305916
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       Start,
   input  logic [DATA_W-1:0]          pxl_in,
   input  logic                       valid_in,
   input  logic                       last_in,
   output logic [DATA_W-1:0]          m_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tlast,
   output logic [level_w(DEPTH)-1:0]  level,
   output logic                       overflow,
   output logic                       frame_done,
   output logic                       count_err
);

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || FRAME_PIXELS == 0) begin : g_param_check
      $error("conv_stream_out: DEPTH must be a power of two >= 4, FRAME_PIXELS nonzero");
   end

   state_t            state_q, state_d;
   logic              overflow_q, overflow_d;
   logic              frame_done_q, frame_done_d;
   logic              pop, accept, abort, start_frame;
   logic              fifo_full, fifo_empty;
   logic [DATA_W:0]   fifo_rd_data;

   assign pop = !fifo_empty && m_axis_tready;

   always_comb begin
      state_d      = state_q;
      overflow_d   = overflow_q;
      accept       = 1'b0;
      abort        = 1'b0;
      start_frame  = 1'b0;
      frame_done_d = pop && fifo_rd_data[DATA_W] && (state_q == DRAIN);
      unique case (state_q)
         IDLE: begin
            if (Start) begin
               state_d     = RUN;
               start_frame = 1'b1;
            end
         end
         RUN: begin
            if (!Start) begin
               abort   = 1'b1;
               state_d = IDLE;
            end else if (valid_in) begin
               // A full FIFO still takes the pixel if the head leaves this same cycle.
               if (fifo_full && !pop) begin
                  overflow_d = 1'b1;
               end else begin
                  accept = 1'b1;
                  if (last_in) state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && fifo_rd_data[DATA_W]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (start_frame) overflow_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         overflow_q   <= overflow_d;
         frame_done_q <= frame_done_d;
      end
   end

   conv_out_fifo #(
      .DEPTH  (DEPTH),
      .WORD_W (DATA_W + 1)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .clear   (abort),
      .wr_en   (accept),
      .wr_data ({last_in, pxl_in}),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

`ifdef CONV_OUT_CNT_EN
   localparam int unsigned CW = $clog2(FRAME_PIXELS + 1) + 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          count_err_q, count_err_d;

   always_comb begin
      cnt_d       = cnt_q;
      count_err_d = count_err_q;
      if (start_frame) begin
         cnt_d       = '0;
         count_err_d = 1'b0;
      end else if (abort) begin
         count_err_d = 1'b1;
      end else if (accept) begin
         cnt_d = cnt_q + 1'b1;
         if (last_in && (cnt_d != CW'(FRAME_PIXELS))) count_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q       <= '0;
         count_err_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         count_err_q <= count_err_d;
      end
   end

   assign count_err = count_err_q;
`else
   assign count_err = 1'b0;
`endif

   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = fifo_rd_data[DATA_W-1:0];
   assign m_axis_tlast  = fifo_rd_data[DATA_W];
   assign overflow      = overflow_q;
   assign frame_done    = frame_done_q;

endmodule
